// File: rtl/vec_pkg.sv
// Shared widths and lane type for the Q8.8 vector packer.
package vec_pkg;

  localparam int unsigned LANES_DEF  = 8;
  localparam int unsigned LANE_W_DEF = 16;
  localparam int unsigned FRAC_W_DEF = 8;
  localparam int unsigned IN_W       = 8;
  localparam int unsigned VCNT_W     = 16;

  typedef logic [15:0] lane_t;

endpackage

// File: rtl/vec_pack_q8.sv
// Packs unsigned bytes into a vector of Q8.8 lanes with a one-deep output slot.
// Optional feature: define VEC_PACK_FLUSH_EN to add a flush port that emits a
// partially filled vector with the unfilled lanes zeroed.
module vec_pack_q8
  import vec_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned LANE_W = LANE_W_DEF,
  parameter int unsigned FRAC_W = FRAC_W_DEF,
  localparam int unsigned CNT_W = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int unsigned VEC_W = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
`ifdef VEC_PACK_FLUSH_EN
  input  logic              flush,
`endif
  output logic [VEC_W-1:0]  out_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  lane_cnt,
  output logic [VCNT_W-1:0] vec_cnt
);

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  logic [LANES-1:0][LANE_W-1:0] asm_q, asm_d, asm_nxt;
  logic [CNT_W-1:0]             lane_cnt_q, lane_cnt_d;
  logic [VEC_W-1:0]             out_vec_q, out_vec_d;
  logic                         out_valid_q, out_valid_d;
  logic [VCNT_W-1:0]            vec_cnt_q, vec_cnt_d;
  logic                         flush_pend_q, flush_pend_d;

  logic consume, slot_free, last_lane, accept, full, flush_go, emit;

  // Handshake decode, assembly update and output slot next-state.
  always_comb begin
    consume   = out_valid_q && out_ready;
    slot_free = !out_valid_q || out_ready;
    last_lane = (lane_cnt_q == LAST_LANE);
    in_ready  = !(last_lane && out_valid_q && !out_ready) && !flush_pend_q;
    accept    = in_valid && in_ready;
    full      = accept && last_lane;
`ifdef VEC_PACK_FLUSH_EN
    flush_go  = (flush || flush_pend_q) && (lane_cnt_q != '0);
`else
    flush_go  = 1'b0;
`endif
    emit      = full || (flush_go && slot_free);

    asm_nxt = asm_q;
    if (accept) begin
      asm_nxt[lane_cnt_q] = LANE_W'(LANE_W'(in_data) << FRAC_W);
    end

    asm_d        = asm_nxt;
    lane_cnt_d   = lane_cnt_q;
    out_vec_d    = out_vec_q;
    out_valid_d  = out_valid_q;
    flush_pend_d = flush_pend_q;
    vec_cnt_d    = consume ? vec_cnt_q + VCNT_W'(1) : vec_cnt_q;

    if (emit) begin
      // Cleared buffer keeps lanes past a flushed partial vector at zero.
      out_vec_d    = asm_nxt;
      out_valid_d  = 1'b1;
      asm_d        = '0;
      lane_cnt_d   = '0;
      flush_pend_d = 1'b0;
    end else begin
      if (accept) begin
        lane_cnt_d = lane_cnt_q + CNT_W'(1);
      end
      if (consume) begin
        out_valid_d = 1'b0;
      end
      if (flush_go) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset discarding all held data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q        <= '0;
      lane_cnt_q   <= '0;
      out_vec_q    <= '0;
      out_valid_q  <= 1'b0;
      vec_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      lane_cnt_q   <= lane_cnt_d;
      out_vec_q    <= out_vec_d;
      out_valid_q  <= out_valid_d;
      vec_cnt_q    <= vec_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign out_vec   = out_vec_q;
  assign out_valid = out_valid_q;
  assign lane_cnt  = lane_cnt_q;
  assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_vec_pack_q8.sv
// Self-checking bench for vec_pack_q8 against a queue-based reference model.
module tb_vec_pack_q8;

  logic         clk, rst;
  logic [7:0]   in_data;
  logic         in_valid, in_ready, out_valid, out_ready, flush;
  logic [127:0] out_vec;
  logic [2:0]   lane_cnt;
  logic [15:0]  vec_cnt;

  logic [7:0]   w_in_data;
  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [15:0]  w_out_vec;
  logic         w_lane_cnt;
  logic [15:0]  w_vec_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   m_asm[$];
  logic [127:0] m_outq[$];
  logic [7:0]   rt_q[$];
  int           m_vcnt = 0;
  bit           m_pend = 0;

  vec_pack_q8 dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef VEC_PACK_FLUSH_EN
    .flush(flush),
`endif
    .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready),
    .lane_cnt(lane_cnt), .vec_cnt(vec_cnt)
  );

  // Single-lane instance so the 16-bit vector counter can wrap quickly.
  vec_pack_q8 #(.LANES(1)) dut_w (
    .clk(clk), .rst(rst), .in_data(w_in_data), .in_valid(w_in_valid), .in_ready(w_in_ready),
`ifdef VEC_PACK_FLUSH_EN
    .flush(1'b0),
`endif
    .out_vec(w_out_vec), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .lane_cnt(w_lane_cnt), .vec_cnt(w_vec_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected vector: each queued byte becomes an integer-valued Q8.8 lane.
  function automatic logic [127:0] mk_vec();
    logic [127:0] v;
    v = '0;
    for (int k = 0; k < m_asm.size(); k++) v[16*k +: 16] = {m_asm[k], 8'h00};
    return v;
  endfunction

  // One clock of stimulus: drive at negedge, check, then advance the model at posedge.
  task automatic step(input logic v, input logic [7:0] d, input logic ordy, input logic fl,
                      output logic acc);
    logic exp_rdy, cons, fgo, sfree;
    in_valid = v; in_data = d; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !(m_asm.size() == 7 && m_outq.size() != 0 && !ordy) && !m_pend;
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("lane_cnt", 128'(lane_cnt), 128'(m_asm.size()));
    chk("out_valid", 128'(out_valid), 128'(m_outq.size() != 0));
    chk("vec_cnt", 128'(vec_cnt), 128'(m_vcnt));
    if (m_outq.size() != 0) chk("out_vec", out_vec, m_outq[0]);
    acc   = v && exp_rdy;
    cons  = (m_outq.size() != 0) && ordy;
    fgo   = (fl || m_pend) && (m_asm.size() != 0);
    sfree = (m_outq.size() == 0) || ordy;
    @(posedge clk);
    if (cons) begin
      void'(m_outq.pop_front());
      m_vcnt = (m_vcnt + 1) % 65536;
    end
    if (acc) begin
      m_asm.push_back(d);
      rt_q.push_back(d);
    end
    if (m_asm.size() == 8) begin
      m_outq.push_back(mk_vec());
      m_asm.delete();
      m_pend = 0;
    end else if (fgo) begin
      if (sfree) begin
        m_outq.push_back(mk_vec());
        m_asm.delete();
        m_pend = 0;
      end else begin
        m_pend = 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic acc, ordy;
    logic [127:0] exp_v;
    int n_acc;
    clk = 0; rst = 1; in_valid = 0; in_data = 0; out_ready = 0; flush = 0;
    w_in_valid = 0; w_in_data = 8'h5A; w_out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_vec", out_vec, 128'(0));
    chk("rst_lane_cnt", 128'(lane_cnt), 128'(0));
    chk("rst_vec_cnt", 128'(vec_cnt), 128'(0));
    chk("rst_w_vec_cnt", 128'(w_vec_cnt), 128'(0));
    rst = 0;
    @(negedge clk);

    // Bytes 1..8 with a ready consumer.
    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b1, 1'b0, acc);
    chk("basic_valid", 128'(out_valid), 128'(1));
    chk("basic_vec", out_vec, 128'h0800_0700_0600_0500_0400_0300_0200_0100);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    chk("basic_vec_cnt", 128'(vec_cnt), 128'(1));
    chk("basic_drain", 128'(out_valid), 128'(0));

    // Backpressure: 16 offers with a stalled consumer, then release.
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, acc);
      if (acc) n_acc++;
    end
    chk("bp_accepted", 128'(n_acc), 128'(15));
    #1;
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    chk("bp_lane_cnt", 128'(lane_cnt), 128'(7));
    @(negedge clk);
    step(1'b1, 8'h1F, 1'b1, 1'b0, acc);
    chk("bp_16th_accepted", 128'(acc), 128'(1));
    chk("bp_no_bubble", 128'(out_valid), 128'(1));
    chk("bp_vec_cnt", 128'(vec_cnt), 128'(2));
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Random traffic with byte-wise round-trip extraction at each handshake.
    rt_q.delete();
    for (int c = 0; c < 400; c++) begin
      ordy = ($urandom_range(0, 3) != 0);
      if (m_outq.size() != 0 && ordy) begin
        for (int k = 0; k < 8; k++) begin
          if (rt_q.size() != 0) chk("roundtrip", 128'(out_vec[16*k+8 +: 8]), 128'(rt_q.pop_front()));
        end
      end
      step($urandom_range(0, 3) != 0, 8'($urandom), ordy, 1'b0, acc);
    end
    while (m_asm.size() != 0) step(1'b1, 8'($urandom), 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Reset in the middle of assembling a vector.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hE0 + i), 1'b1, 1'b0, acc);
    rst = 1;
    #1;
    chk("midrst_lane_cnt", 128'(lane_cnt), 128'(0));
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_vec_cnt", 128'(vec_cnt), 128'(0));
    m_asm.delete(); m_outq.delete(); m_vcnt = 0; m_pend = 0;
    @(negedge clk);
    rst = 0;
    exp_v = '0;
    for (int i = 0; i < 8; i++) begin
      exp_v[16*i +: 16] = {8'(8'h21 + i), 8'h00};
      step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0, acc);
    end
    chk("midrst_clean_vec", out_vec, exp_v);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);

`ifdef VEC_PACK_FLUSH_EN
    // Partial flush, flush when empty, and a flush held pending on a busy slot.
    step(1'b1, 8'hAA, 1'b1, 1'b0, acc);
    step(1'b1, 8'hBB, 1'b1, 1'b0, acc);
    step(1'b1, 8'hCC, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b1, acc);
    chk("flush_valid", 128'(out_valid), 128'(1));
    chk("flush_vec", out_vec, 128'h0000_0000_0000_0000_0000_CC00_BB00_AA00);
    step(1'b0, 8'h00, 1'b1, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, 1'b1, acc);
    chk("flush_empty_ignored", 128'(out_valid), 128'(0));
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, acc);
    step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    #1;
    chk("flush_pend_in_ready", 128'(in_ready), 128'(0));
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h77, 1'b1, 1'b0, acc);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
`endif

    // Counter wrap on the single-lane instance: one vector per cycle.
    w_in_valid = 1; w_out_ready = 1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    chk("wrap_ffff", 128'(w_vec_cnt), 128'(16'hFFFF));
    w_in_valid = 0;
    @(negedge clk);
    chk("wrap_zero", 128'(w_vec_cnt), 128'(0));
    chk("wrap_drained", 128'(w_out_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
